// File: rtl/fb_access_arbiter_if.sv
// rtl/fb_access_arbiter_if.sv - video/CPU/fill/RAM signal bundle for fb_access_arbiter
interface fb_access_arbiter_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
);
  logic              VID_REQ;
  logic [ADDR_W-1:0] VID_ADDR;
  logic [DATA_W-1:0] VID_DATA;
  logic              VID_VALID;
  logic              VID_MISS;
  logic              CPU_WR;
  logic [ADDR_W-1:0] CPU_ADDR;
  logic [DATA_W-1:0] CPU_DATA;
  logic              CPU_FULL;
  logic              CPU_ERR;
  logic              FILL_START;
  logic [DATA_W-1:0] FILL_COLOR;
  logic              FILL_BUSY;
  logic              FILL_DONE;
  logic [ADDR_W-1:0] RAM_ADDR;
  logic              RAM_WE;
  logic [DATA_W-1:0] RAM_WDATA;
  logic [DATA_W-1:0] RAM_RDATA;

  modport slave (
    input  VID_REQ, VID_ADDR, CPU_WR, CPU_ADDR, CPU_DATA, FILL_START, FILL_COLOR, RAM_RDATA,
    output VID_DATA, VID_VALID, VID_MISS, CPU_FULL, CPU_ERR, FILL_BUSY, FILL_DONE,
           RAM_ADDR, RAM_WE, RAM_WDATA
  );

  modport master (
    output VID_REQ, VID_ADDR, CPU_WR, CPU_ADDR, CPU_DATA, FILL_START, FILL_COLOR, RAM_RDATA,
    input  VID_DATA, VID_VALID, VID_MISS, CPU_FULL, CPU_ERR, FILL_BUSY, FILL_DONE,
           RAM_ADDR, RAM_WE, RAM_WDATA
  );
endinterface

// File: rtl/fb_access_arbiter.sv
// rtl/fb_access_arbiter.sv - fixed-priority framebuffer RAM arbiter (video > CPU queue > fill)
// Optional starvation guard for queued CPU writes: FB_ARB_STARVE_GUARD_EN.
module fb_access_arbiter #(
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 8,
  parameter int FB_DEPTH   = 19200,
  parameter int BASE_ADDR  = 4096,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 64
) (
  input logic CLK_SYS,
  input logic RESET,
  fb_access_arbiter_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(FB_DEPTH);
  localparam logic [ADDR_W-1:0] FB_LAST = ADDR_W'(FB_DEPTH - 1);

  typedef enum logic {IDLE, RUN} fill_state_t;

  logic [ADDR_W-1:0] q_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] q_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count;
  logic              q_empty, q_full;

  fill_state_t       state, state_n;
  logic [ADDR_W-1:0] fill_ctr, fill_ctr_n;
  logic [DATA_W-1:0] color, color_n;
  logic              done_n, done_q;

  logic [ADDR_W-1:0] addr_q, ram_addr_c, offset;
  logic [DATA_W-1:0] ram_wdata_c;
  logic              ram_we_c, vid_gnt, pop, fill_gnt, force_cpu;
  logic              in_range, push, drop, err_q, vid_valid_q;

  assign q_empty = (count == '0);
  assign q_full  = (count == CNT_W'(FIFO_DEPTH));

`ifdef FB_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(STARVE_MAX + 1);
  logic [WAIT_W-1:0] wait_ctr;

  assign force_cpu = !q_empty && (wait_ctr >= WAIT_W'(STARVE_MAX));

  always_ff @(posedge CLK_SYS) begin
    if (RESET)
      wait_ctr <= '0;
    else if (pop)
      wait_ctr <= '0;
    else if (!q_empty && (wait_ctr < WAIT_W'(STARVE_MAX)))
      wait_ctr <= wait_ctr + WAIT_W'(1);
  end
`else
  // Strict priority: video is never pre-empted (expression is constant 0).
  assign force_cpu = (STARVE_MAX < 0);
`endif

  // One requester per cycle; RESET blocks every grant so nothing reaches the RAM mid-reset.
  always_comb begin
    vid_gnt     = 1'b0;
    pop         = 1'b0;
    fill_gnt    = 1'b0;
    ram_addr_c  = addr_q;
    ram_we_c    = 1'b0;
    ram_wdata_c = '0;
    if (!RESET) begin
      if (bus.VID_REQ && !force_cpu) begin
        vid_gnt    = 1'b1;
        ram_addr_c = bus.VID_ADDR;
      end else if (!q_empty) begin
        pop         = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = q_addr[rd_ptr];
        ram_wdata_c = q_data[rd_ptr];
      end else if (state == RUN) begin
        fill_gnt    = 1'b1;
        ram_we_c    = 1'b1;
        ram_addr_c  = fill_ctr;
        ram_wdata_c = color;
      end
    end
  end

  assign offset   = bus.CPU_ADDR - BASE;
  assign in_range = (bus.CPU_ADDR >= BASE) && (offset < FB_SIZE);
  assign push     = bus.CPU_WR && in_range && (!q_full || pop);
  assign drop     = bus.CPU_WR && !push;

  always_ff @(posedge CLK_SYS) begin
    if (push) begin
      q_addr[wr_ptr] <= offset;
      q_data[wr_ptr] <= bus.CPU_DATA;
    end
  end

  always_comb begin
    state_n    = state;
    fill_ctr_n = fill_ctr;
    color_n    = color;
    done_n     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.FILL_START) begin
          state_n    = RUN;
          fill_ctr_n = '0;
          color_n    = bus.FILL_COLOR;
        end
      end
      RUN: begin
        if (fill_gnt) begin
          if (fill_ctr == FB_LAST) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            fill_ctr_n = fill_ctr + ADDR_W'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge CLK_SYS) begin
    if (RESET) begin
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      vid_valid_q <= 1'b0;
      state       <= IDLE;
      fill_ctr    <= '0;
      color       <= '0;
      done_q      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count       <= count + CNT_W'(push) - CNT_W'(pop);
      err_q       <= err_q | drop;
      addr_q      <= ram_addr_c;
      vid_valid_q <= vid_gnt;
      state       <= state_n;
      fill_ctr    <= fill_ctr_n;
      color       <= color_n;
      done_q      <= done_n;
    end
  end

  assign bus.RAM_ADDR  = ram_addr_c;
  assign bus.RAM_WE    = ram_we_c;
  assign bus.RAM_WDATA = ram_wdata_c;
  assign bus.VID_VALID = vid_valid_q;
  assign bus.VID_DATA  = vid_valid_q ? bus.RAM_RDATA : '0;
  assign bus.VID_MISS  = !RESET && force_cpu && bus.VID_REQ;
  assign bus.CPU_FULL  = q_full;
  assign bus.CPU_ERR   = err_q;
  assign bus.FILL_BUSY = (state == RUN);
  assign bus.FILL_DONE = done_q;

endmodule

// File: tb/tb_fb_access_arbiter.sv
// tb/tb_fb_access_arbiter.sv - randomized bench for fb_access_arbiter against a queue-based model
module tb_fb_access_arbiter;

  localparam int ADDR_W     = 15;
  localparam int DATA_W     = 8;
  localparam int FB_DEPTH   = 19200;
  localparam int BASE_ADDR  = 4096;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 64;
`ifdef FB_ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fb_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_access_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FB_DEPTH(FB_DEPTH), .BASE_ADDR(BASE_ADDR),
    .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .CLK_SYS(clk),
    .RESET(rst),
    .bus(bus)
  );

  logic [DATA_W-1:0] ram  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] mmem [0:(1<<ADDR_W)-1];

  always @(posedge clk) begin
    if (bus.RAM_WE) ram[bus.RAM_ADDR] <= bus.RAM_WDATA;
    bus.RAM_RDATA <= ram[bus.RAM_ADDR];
  end

  typedef struct { int addr; int data; } wr_t;
  wr_t q[$];
  int  m_err, m_busy, m_ctr, m_color, m_done, m_wait, m_last_addr, m_vv, m_vdata;
  int  checks = 0;
  int  errors = 0;
  int  seen_we, seen_miss;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_err = 0; m_busy = 0; m_ctr = 0; m_color = 0; m_done = 0;
    m_wait = 0; m_last_addr = 0; m_vv = 0; m_vdata = 0;
  endtask

  task automatic drive_idle();
    bus.VID_REQ = 0; bus.VID_ADDR = '0; bus.CPU_WR = 0; bus.CPU_ADDR = '0;
    bus.CPU_DATA = '0; bus.FILL_START = 0; bus.FILL_COLOR = '0;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst = 1'b1;
    drive_idle();
    repeat (n) @(posedge clk);
    #1;
    check("rst_ram_we", bus.RAM_WE, 0);
    check("rst_ram_addr", bus.RAM_ADDR, 0);
    check("rst_vid_valid", bus.VID_VALID, 0);
    check("rst_vid_miss", bus.VID_MISS, 0);
    check("rst_cpu_full", bus.CPU_FULL, 0);
    check("rst_cpu_err", bus.CPU_ERR, 0);
    check("rst_fill_busy", bus.FILL_BUSY, 0);
    check("rst_fill_done", bus.FILL_DONE, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; predictions come from the queue model before it advances.
  task automatic step(input bit vreq, input int vaddr, input bit wr, input int caddr,
                      input int cdata, input bit fst, input int fcol);
    bit force_c, vid, pop, fillg, nonempty;
    int e_we, e_addr, e_wd;
    @(negedge clk);
    bus.VID_REQ = vreq; bus.VID_ADDR = ADDR_W'(vaddr);
    bus.CPU_WR = wr; bus.CPU_ADDR = ADDR_W'(caddr); bus.CPU_DATA = DATA_W'(cdata);
    bus.FILL_START = fst; bus.FILL_COLOR = DATA_W'(fcol);
    #1;
    nonempty = q.size() > 0;
    force_c  = GUARD && nonempty && (m_wait >= STARVE_MAX);
    vid      = vreq && !force_c;
    pop      = !vid && nonempty;
    fillg    = !vid && !pop && (m_busy != 0);
    e_we = 0; e_addr = m_last_addr; e_wd = 0;
    if (vid) e_addr = vaddr;
    else if (pop) begin e_we = 1; e_addr = q[0].addr; e_wd = q[0].data; end
    else if (fillg) begin e_we = 1; e_addr = m_ctr; e_wd = m_color; end

    check("ram_we", bus.RAM_WE, e_we);
    check("ram_addr", bus.RAM_ADDR, e_addr);
    if (e_we != 0) check("ram_wdata", bus.RAM_WDATA, e_wd);
    check("vid_valid", bus.VID_VALID, m_vv);
    if (m_vv != 0) check("vid_data", bus.VID_DATA, m_vdata);
    check("vid_miss", bus.VID_MISS, force_c && vreq);
    check("cpu_full", bus.CPU_FULL, q.size() == FIFO_DEPTH);
    check("cpu_err", bus.CPU_ERR, m_err);
    check("fill_busy", bus.FILL_BUSY, m_busy);
    check("fill_done", bus.FILL_DONE, m_done);
    seen_we   += bus.RAM_WE;
    seen_miss += bus.VID_MISS;

    m_vv = vid;
    if (vid) m_vdata = mmem[vaddr];
    if (e_we != 0) mmem[e_addr] = DATA_W'(e_wd);
    if (vid || e_we != 0) m_last_addr = e_addr;
    if (pop) void'(q.pop_front());
    if (pop) m_wait = 0;
    else if (nonempty) m_wait++;
    if (wr) begin
      if (caddr < BASE_ADDR || caddr - BASE_ADDR >= FB_DEPTH || q.size() == FIFO_DEPTH)
        m_err = 1;
      else
        q.push_back('{addr: caddr - BASE_ADDR, data: cdata});
    end
    m_done = 0;
    if (m_busy != 0) begin
      if (fillg) begin
        if (m_ctr == FB_DEPTH - 1) begin m_busy = 0; m_done = 1; end
        else m_ctr++;
      end
    end else if (fst) begin
      m_busy = 1; m_ctr = 0; m_color = fcol;
    end
  endtask

  initial begin
    int bad;
    for (int i = 0; i < (1 << ADDR_W); i++) begin ram[i] = '0; mmem[i] = '0; end
    drive_idle();
    model_reset();
    seen_we = 0; seen_miss = 0;
    do_reset(2);

    // Single CPU write to word 0, retired the cycle after the push
    step(0, 0, 1, 4096, 8'h05, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t1_word0", ram[0], 8'h05);

    // Video held high blocks three writes; they retire in order afterwards
    for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 32767), 1, 4200 + i, 8'h10 + i, 0, 0);
    for (int i = 0; i < 3; i++) step(1, $urandom_range(0, 32767), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("t2_word", ram[106], 8'h12);

    // Overflow under video, then out-of-range addresses
    do_reset(1);
    for (int i = 0; i < 5; i++) step(1, i, 1, 5000 + i, i, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    check("t3_full_err", {bus.CPU_FULL, bus.CPU_ERR}, 2'b11);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0);
    do_reset(1);
    step(0, 0, 1, 4095, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t3_low_err", bus.CPU_ERR, 1);
    do_reset(1);
    step(0, 0, 1, 23296, 1, 0, 0);
    step(0, 0, 1, 23295, 8'h77, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t3_high_err", bus.CPU_ERR, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t3_last_word", ram[19199], 8'h77);

    // Full-buffer fill with a restart attempt mid-run
    step(0, 0, 0, 0, 0, 1, 8'h03);
    for (int i = 0; i < 25000 && m_busy != 0; i++)
      step(0, 0, 0, 0, 0, (i == 5000), 8'h7e);
    step(0, 0, 0, 0, 0, 0, 0);
    check("t4_busy_low", bus.FILL_BUSY, 0);
    bad = 0;
    for (int i = 0; i < FB_DEPTH; i++) if (ram[i] != 8'h03) bad++;
    check("t4_bad_words", bad, 0);

    // Reset while the fill is about to write word 100
    step(0, 0, 0, 0, 0, 1, 8'h5a);
    for (int i = 0; i < 200 && m_ctr < 100; i++) step(0, 0, 0, 0, 0, 0, 0);
    seen_we = 0;
    do_reset(1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 0, 0, 0);
    check("t5_no_writes", seen_we, 0);
    check("t5_word100", ram[100], 8'h03);

    // Randomized mixed traffic
    for (int i = 0; i < 3000; i++) begin
      int r, ca;
      r = $urandom_range(0, 9);
      case (r)
        0: ca = 4095;
        1: ca = 23296;
        2: ca = 4096;
        3: ca = 23295;
        4: ca = $urandom_range(0, 32767);
        default: ca = $urandom_range(4096, 23295);
      endcase
      step($urandom_range(0, 99) < 60, $urandom_range(0, 32767), $urandom_range(0, 99) < 40,
           ca, $urandom_range(0, 255), $urandom_range(0, 499) == 0, $urandom_range(0, 255));
    end
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0, 0, 0);

    // Video stuck high with one queued write
    do_reset(1);
    seen_we = 0; seen_miss = 0;
    step(1, 3, 1, 4096 + 7, 8'h44, 0, 0);
    for (int i = 0; i < 80; i++) step(1, $urandom_range(0, 32767), 0, 0, 0, 0, 0);
    check("t6_forced_writes", seen_we, GUARD ? 1 : 0);
    check("t6_misses", seen_miss, GUARD ? 1 : 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0);

    bad = 0;
    for (int i = 0; i < (1 << ADDR_W); i++) if (ram[i] !== mmem[i]) bad++;
    check("final_mem_diff", bad, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
